// File: rtl/tx_link_arbiter.sv
// tx_link_arbiter: packet-atomic TLP/DLLP link arbiter with periodic SKP ordered-set insertion.
// DLLPs win over TLPs until a burst limit is reached while a TLP is waiting.
module tx_link_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int SKP_INTERVAL   = 1180,
    parameter int SKP_COUNT      = 3,
    parameter int DLLP_BURST_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] tlp_data_i,
    input  logic                  tlp_valid_i,
    input  logic                  tlp_last_i,
    output logic                  tlp_ready_o,
    input  logic [DATA_WIDTH-1:0] dllp_data_i,
    input  logic                  dllp_valid_i,
    input  logic                  dllp_last_i,
    output logic                  dllp_ready_o,
    input  logic                  link_up_i,
    output logic [DATA_WIDTH-1:0] data_frame_o,
    output logic                  data_frame_valid_o,
    output logic                  is_special_k_o,
    output logic [1:0]            grant_o
);
    localparam int CW = $clog2(SKP_INTERVAL + 1);
    localparam int BW = $clog2(DLLP_BURST_MAX + 1);
    localparam int SW = $clog2(SKP_COUNT + 1);

    typedef enum logic [2:0] {IDLE, TLP, DLLP, SKP_COM, SKP} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   skp_cnt;
    logic            skp_pend;
    logic [BW-1:0]   burst;
    logic [SW-1:0]   sym;
    logic            tlp_xfer, dllp_xfer, skp_full, burst_full, dllp_win;
    logic            skp_start, skp_emit, tlp_grant, dllp_grant;

    assign tlp_ready_o  = (state == TLP) && link_up_i;
    assign dllp_ready_o = (state == DLLP) && link_up_i;
    assign tlp_xfer     = tlp_valid_i && tlp_ready_o;
    assign dllp_xfer    = dllp_valid_i && dllp_ready_o;
    assign skp_full     = skp_cnt == CW'(SKP_INTERVAL);
    assign burst_full   = burst == BW'(DLLP_BURST_MAX);
    // A saturated burst only blocks DLLPs when a TLP is actually waiting
    assign dllp_win     = dllp_valid_i && !(burst_full && tlp_valid_i);
    assign skp_start    = (state == IDLE) && link_up_i && skp_pend;
    assign skp_emit     = link_up_i && (state == SKP_COM || state == SKP);
    assign tlp_grant    = (state == IDLE) && (state_nx == TLP);
    assign dllp_grant   = (state == IDLE) && (state_nx == DLLP);
    assign grant_o      = (state == TLP) ? 2'd1 : (state == DLLP) ? 2'd2 :
                          (state == SKP_COM || state == SKP) ? 2'd3 : 2'd0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = skp_pend ? SKP_COM : dllp_win ? DLLP : tlp_valid_i ? TLP : IDLE;
            TLP:     state_nx = (tlp_xfer && tlp_last_i) ? IDLE : TLP;
            DLLP:    state_nx = (dllp_xfer && dllp_last_i) ? IDLE : DLLP;
            SKP_COM: state_nx = SKP;
            SKP:     state_nx = (sym == SW'(SKP_COUNT - 1)) ? IDLE : SKP;
            default: state_nx = IDLE;
        endcase
        if (!link_up_i) state_nx = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state              <= IDLE;
            skp_cnt            <= '0;
            skp_pend           <= 1'b0;
            burst              <= '0;
            sym                <= '0;
            data_frame_o       <= '0;
            data_frame_valid_o <= 1'b0;
            is_special_k_o     <= 1'b0;
        end else begin
            state    <= state_nx;
            sym      <= (state == SKP) ? sym + 1'b1 : '0;
            skp_cnt  <= (!link_up_i || skp_start) ? '0 : skp_full ? skp_cnt : skp_cnt + 1'b1;
            skp_pend <= link_up_i && !skp_start && (skp_pend || skp_full);
            if (!link_up_i || tlp_grant)
                burst <= '0;
            else if (dllp_grant)
                burst <= !tlp_valid_i ? '0 : burst_full ? burst : burst + 1'b1;
            data_frame_valid_o <= tlp_xfer || dllp_xfer || skp_emit;
            is_special_k_o     <= skp_emit;
            if (tlp_xfer)
                data_frame_o <= tlp_data_i;
            else if (dllp_xfer)
                data_frame_o <= dllp_data_i;
            else if (skp_emit)
                data_frame_o <= (state == SKP_COM) ? DATA_WIDTH'(8'hBC) : DATA_WIDTH'(8'h1C);
        end
    end
endmodule

// File: tb/tb_tx_link_arbiter.sv
// tb_tx_link_arbiter: directed stimulus with an expected-byte queue drained by an output monitor.
module tb_tx_link_arbiter;
    logic       clk, rst_n;
    logic [7:0] tlp_data, dllp_data, data_frame;
    logic       tlp_valid, tlp_last, tlp_ready;
    logic       dllp_valid, dllp_last, dllp_ready;
    logic       link_up, frame_valid, special_k;
    logic [1:0] grant;

    int         vectors = 0;
    int         miscompares = 0;
    logic [8:0] exp_q[$];
    logic [8:0] e;
    int         w, n;

    tx_link_arbiter #(.DATA_WIDTH(8), .SKP_INTERVAL(16), .SKP_COUNT(3), .DLLP_BURST_MAX(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .tlp_data_i(tlp_data), .tlp_valid_i(tlp_valid), .tlp_last_i(tlp_last), .tlp_ready_o(tlp_ready),
        .dllp_data_i(dllp_data), .dllp_valid_i(dllp_valid), .dllp_last_i(dllp_last), .dllp_ready_o(dllp_ready),
        .link_up_i(link_up), .data_frame_o(data_frame), .data_frame_valid_o(frame_valid),
        .is_special_k_o(special_k), .grant_o(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_unexpected: got k=%0b data=%h, no byte expected", special_k, data_frame);
            end else begin
                e = exp_q.pop_front();
                if ({special_k, data_frame} !== e) begin
                    miscompares++;
                    $display("FAIL out_byte: got k=%0b data=%h, expected k=%0b data=%h",
                             special_k, data_frame, e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic exp_pkt(input logic [7:0] base, input int cnt);
        for (int i = 0; i < cnt; i++) exp_q.push_back({1'b0, base + 8'(i)});
    endtask

    task automatic exp_skp();
        exp_q.push_back({1'b1, 8'hBC});
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 8'h1C});
    endtask

    task automatic xfer_byte(input bit d, input logic [7:0] b, input logic l, output int waits);
        logic x;
        int   k;
        if (d) begin dllp_data = b; dllp_last = l; dllp_valid = 1'b1; end
        else   begin tlp_data = b;  tlp_last = l;  tlp_valid = 1'b1;  end
        x = 1'b0; k = 0; waits = 0;
        while (!x && k < 64) begin
            @(negedge clk);
            x = d ? dllp_ready : tlp_ready;
            @(posedge clk); #1;
            if (!x) waits++;
            k++;
        end
        if (!x) begin
            vectors++; miscompares++;
            $display("FAIL xfer_timeout: got no ready in %0d cycles, expected ready", k);
        end
    endtask

    task automatic send_pkt(input bit d, input logic [7:0] base, input int cnt, output int waits);
        int ww;
        waits = 0;
        for (int i = 0; i < cnt; i++) begin
            xfer_byte(d, base + 8'(i), i == cnt - 1, ww);
            waits += ww;
        end
        if (d) dllp_valid = 1'b0; else tlp_valid = 1'b0;
    endtask

    task automatic wait_grant(input logic [1:0] g, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (grant !== g && cnt < 100);
    endtask

    task automatic link_down();
        link_up = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; link_up = 1'b0;
        tlp_data = '0; tlp_valid = 1'b0; tlp_last = 1'b0;
        dllp_data = '0; dllp_valid = 1'b0; dllp_last = 1'b0;
        #3;
        chk("rst_data", data_frame, 0);
        chk("rst_valid", frame_valid, 0);
        chk("rst_k", special_k, 0);
        chk("rst_tlp_ready", tlp_ready, 0);
        chk("rst_dllp_ready", dllp_ready, 0);
        chk("rst_grant", grant, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        link_down();

        // single 3-byte TLP
        exp_pkt(8'hA1, 3);
        link_up = 1'b1;
        chk("t1_idle_grant", grant, 0);
        send_pkt(0, 8'hA1, 3, w);
        chk("t1_idle_cycles", w, 1);
        chk("t1_grant_after", grant, 0);
        chk("t1_ready_after", tlp_ready, 0);
        link_down();

        // contention: 4 DLLPs, then the waiting TLP, then the 5th DLLP
        exp_pkt(8'hD1, 4);
        exp_pkt(8'hE1, 2);
        exp_pkt(8'hD5, 1);
        link_up = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    int wd;
                    send_pkt(1, 8'hD1 + 8'(i), 1, wd);
                end
            end
            begin
                int wt;
                send_pkt(0, 8'hE1, 2, wt);
                chk("t2_tlp_wait", wt, 9);
            end
        join
        link_down();

        // SKP deferred behind a long TLP, then the interval restarts from zero
        exp_pkt(8'h10, 20);
        exp_skp();
        exp_skp();
        link_up = 1'b1;
        send_pkt(0, 8'h10, 20, w);
        chk("t3_idle_cycles", w, 1);
        @(posedge clk); #1;
        chk("t3_skp_after_last", grant, 3);
        wait_grant(2'd0, n);
        chk("t3_skp_len", n, 4);
        wait_grant(2'd3, n);
        chk("t3_skp_restart", n, 14);
        wait_grant(2'd0, n);
        chk("t3_skp2_done", grant, 0);
        link_down();

        // mid-packet stall of two cycles
        exp_pkt(8'hB1, 4);
        link_up = 1'b1;
        xfer_byte(0, 8'hB1, 1'b0, w);
        xfer_byte(0, 8'hB2, 1'b0, w);
        tlp_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("t4_stall_grant", grant, 1);
            chk("t4_stall_valid", frame_valid, 0);
        end
        xfer_byte(0, 8'hB3, 1'b0, w);
        chk("t4_resume_wait", w, 0);
        xfer_byte(0, 8'hB4, 1'b1, w);
        tlp_valid = 1'b0;
        link_down();

        // link drop mid-DLLP
        exp_pkt(8'hC1, 2);
        link_up = 1'b1;
        xfer_byte(1, 8'hC1, 1'b0, w);
        xfer_byte(1, 8'hC2, 1'b0, w);
        link_up = 1'b0;
        #1;
        chk("t5_ready_drop", dllp_ready, 0);
        chk("t5_grant_hold", grant, 2);
        @(posedge clk); #1;
        chk("t5_idle_next", grant, 0);
        dllp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_skp();
        link_up = 1'b1;
        wait_grant(2'd3, n);
        chk("t5_skp_delay", n, 18);
        wait_grant(2'd0, n);
        chk("t5_skp_done", grant, 0);
        link_down();

        // asynchronous reset in the middle of an ordered set
        exp_q.push_back({1'b1, 8'hBC});
        link_up = 1'b1;
        wait_grant(2'd3, n);
        chk("t6_skp_delay", n, 18);
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("t6_pre_valid", frame_valid, 1);
        chk("t6_pre_k", special_k, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_data", data_frame, 0);
        chk("t6_rst_valid", frame_valid, 0);
        chk("t6_rst_k", special_k, 0);
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_tlp_ready", tlp_ready, 0);
        chk("t6_rst_dllp_ready", dllp_ready, 0);
        link_up = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // first grant in the second cycle after reset release
        exp_pkt(8'h51, 1);
        link_up = 1'b1;
        send_pkt(0, 8'h51, 1, w);
        chk("t7_first_grant", w, 1);
        link_down();

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
